fwd_combine: RTL and testbench

//  2:1 combiner between two packet-buffer sources (BPFVM or child combiner) and one forwarder.

---
 rtl/fwd_pkg.sv | 22 ++
 rtl/fwd_rr_arbiter.sv | 45 ++++
 rtl/fwd_combine.sv | 92 +++++++++
 tb/tb_fwd_combine.sv | 362 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fwd_pkg.sv
// Shared types and helpers for the forwarder combiner tree.
// Side-select encoding and packet-length width derivation.
package fwd_pkg;

    typedef enum logic {
        SEL_LEFT  = 1'b0,
        SEL_RIGHT = 1'b1
    } fwd_sel_t;

    localparam int DEF_DATA_WIDTH = 64;
    localparam int DEF_ADDR_WIDTH = 10;

    // A packet may fill the whole buffer, so length needs one bit more than the address.
    function automatic int plen_w(input int addr_width);
        return addr_width + 1;
    endfunction

    function automatic fwd_sel_t other_side(input fwd_sel_t side);
        return (side == SEL_LEFT) ? SEL_RIGHT : SEL_LEFT;
    endfunction

endpackage

// File: rtl/fwd_rr_arbiter.sv
// Round-robin owner select for one combiner node.
// A done pulse always hands over; otherwise switch only to claim an idle port.
//
//  state     | meaning
//  SEL_LEFT  | left source owns the forwarder read port
//  SEL_RIGHT | right source owns the forwarder read port
module fwd_rr_arbiter
    import fwd_pkg::*;
(
    input  logic     clk,
    input  logic     rst_n,
    input  logic     ready_l,
    input  logic     ready_r,
    input  logic     done,
    output fwd_sel_t sel
);

    fwd_sel_t r_sel;
    fwd_sel_t w_sel_nxt;
    logic     w_ready_own;
    logic     w_ready_oth;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_sel <= SEL_LEFT;
        end else begin
            r_sel <= w_sel_nxt;
        end
    end

    always_comb begin
        w_sel_nxt   = r_sel;
        w_ready_own = (r_sel == SEL_LEFT) ? ready_l : ready_r;
        w_ready_oth = (r_sel == SEL_LEFT) ? ready_r : ready_l;
        // Done wins even if the finished side still shows ready for a cycle.
        if (done) begin
            w_sel_nxt = other_side(r_sel);
        end else if (!w_ready_own && w_ready_oth) begin
            w_sel_nxt = other_side(r_sel);
        end
    end

    assign sel = r_sel;

endmodule

// File: rtl/fwd_combine.sv
// 2:1 combiner between two packet-buffer sources and one forwarder; cascadable into a tree.
// Optional macro RD_DATA_REG_EN adds a register stage on the returned read data.
module fwd_combine
    import fwd_pkg::*;
#(
    parameter  int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter  int ADDR_WIDTH = DEF_ADDR_WIDTH,
    localparam int PLEN_W     = plen_w(ADDR_WIDTH)
) (
    input  logic                  clk,
    input  logic                  rst_n,

    output logic [ADDR_WIDTH-1:0] forwarder_rd_addr_left,
    input  logic [DATA_WIDTH-1:0] forwarder_rd_data_left,
    output logic                  forwarder_rd_en_left,
    output logic                  forwarder_done_left,
    input  logic                  ready_for_forwarder_left,
    input  logic [PLEN_W-1:0]     len_to_forwarder_left,

    output logic [ADDR_WIDTH-1:0] forwarder_rd_addr_right,
    input  logic [DATA_WIDTH-1:0] forwarder_rd_data_right,
    output logic                  forwarder_rd_en_right,
    output logic                  forwarder_done_right,
    input  logic                  ready_for_forwarder_right,
    input  logic [PLEN_W-1:0]     len_to_forwarder_right,

    input  logic [ADDR_WIDTH-1:0] forwarder_rd_addr,
    output logic [DATA_WIDTH-1:0] forwarder_rd_data,
    input  logic                  forwarder_rd_en,
    input  logic                  forwarder_done,
    output logic                  ready_for_forwarder,
    output logic [PLEN_W-1:0]     len_to_forwarder
);

    fwd_sel_t w_sel_q;
    fwd_sel_t w_sel;
    fwd_sel_t r_data_sel;
    logic     w_own_right;

    fwd_rr_arbiter u_arb (
        .clk     (clk),
        .rst_n   (rst_n),
        .ready_l (ready_for_forwarder_left),
        .ready_r (ready_for_forwarder_right),
        .done    (forwarder_done),
        .sel     (w_sel_q)
    );

    // While reset is held the left side is presented, independent of any clock edge.
    assign w_sel       = rst_n ? w_sel_q : SEL_LEFT;
    assign w_own_right = (w_sel == SEL_RIGHT);

    // Sources answer one cycle after rd_en, so the data mux follows the previous owner.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_data_sel <= SEL_LEFT;
        end else begin
            r_data_sel <= w_sel_q;
        end
    end

    assign ready_for_forwarder = w_own_right ? ready_for_forwarder_right : ready_for_forwarder_left;
    assign len_to_forwarder    = w_own_right ? len_to_forwarder_right : len_to_forwarder_left;

    assign forwarder_rd_addr_left  = forwarder_rd_addr;
    assign forwarder_rd_addr_right = forwarder_rd_addr;
    assign forwarder_rd_en_left    = forwarder_rd_en & ~w_own_right;
    assign forwarder_rd_en_right   = forwarder_rd_en & w_own_right;
    assign forwarder_done_left     = forwarder_done & ~w_own_right;
    assign forwarder_done_right    = forwarder_done & w_own_right;

`ifdef RD_DATA_REG_EN
    logic [DATA_WIDTH-1:0] r_rd_data;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_rd_data <= '0;
        end else begin
            r_rd_data <= (r_data_sel == SEL_RIGHT) ? forwarder_rd_data_right : forwarder_rd_data_left;
        end
    end

    assign forwarder_rd_data = r_rd_data;
`else
    fwd_sel_t w_data_sel;

    assign w_data_sel        = rst_n ? r_data_sel : SEL_LEFT;
    assign forwarder_rd_data = (w_data_sel == SEL_RIGHT) ? forwarder_rd_data_right
                                                         : forwarder_rd_data_left;
`endif

endmodule

// File: tb/tb_fwd_combine.sv
// Self-checking bench for fwd_combine: owner model plus directed vectors, and a 4-leaf tree.
// Build with RD_DATA_REG_EN defined to check the registered-data variant.
module tb_fwd_combine;

    localparam int DW = 64;
    localparam int AW = 10;
    localparam int PW = AW + 1;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [AW-1:0] addr_l, addr_r, f_addr;
    logic [DW-1:0] data_l = '0, data_r = '0, f_data;
    logic          en_l, en_r, done_l, done_r;
    logic          rdy_l, rdy_r, f_en, f_done, f_rdy;
    logic [PW-1:0] len_l, len_r, f_len;

    fwd_combine #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) u_dut (
        .clk                       (clk),
        .rst_n                     (rst_n),
        .forwarder_rd_addr_left    (addr_l),
        .forwarder_rd_data_left    (data_l),
        .forwarder_rd_en_left      (en_l),
        .forwarder_done_left       (done_l),
        .ready_for_forwarder_left  (rdy_l),
        .len_to_forwarder_left     (len_l),
        .forwarder_rd_addr_right   (addr_r),
        .forwarder_rd_data_right   (data_r),
        .forwarder_rd_en_right     (en_r),
        .forwarder_done_right      (done_r),
        .ready_for_forwarder_right (rdy_r),
        .len_to_forwarder_right    (len_r),
        .forwarder_rd_addr         (f_addr),
        .forwarder_rd_data         (f_data),
        .forwarder_rd_en           (f_en),
        .forwarder_done            (f_done),
        .ready_for_forwarder       (f_rdy),
        .len_to_forwarder          (f_len)
    );

    // Packet-buffer sources: one-cycle read latency, hold last data.
    logic [DW-1:0] mem_l [16];
    logic [DW-1:0] mem_r [16];
    always @(posedge clk) begin
        if (en_l) data_l <= mem_l[addr_l[3:0]];
        if (en_r) data_r <= mem_r[addr_r[3:0]];
    end

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
        end
    endtask

    // Model: who owns the port, who owned it one cycle ago, and the registered data value.
    int            m_own  = 0;
    int            m_prev = 0;
    logic [DW-1:0] m_reg  = '0;
    logic          chk_en = 1'b0;

    always @(posedge clk) begin
        logic rdy [2];
        rdy[0] = rdy_l;
        rdy[1] = rdy_r;
        if (!rst_n) begin
            m_own  = 0;
            m_prev = 0;
            m_reg  = '0;
        end else begin
            m_reg  = (m_prev == 1) ? data_r : data_l;
            m_prev = m_own;
            if (f_done)                            m_own = 1 - m_own;
            else if (!rdy[m_own] && rdy[1 - m_own]) m_own = 1 - m_own;
        end
    end

    always @(negedge clk) begin
        int own;
        int dsel;
        own  = rst_n ? m_own : 0;
        dsel = rst_n ? m_prev : 0;
        if (chk_en) begin
            chk("ready", f_rdy, (own == 1) ? rdy_r : rdy_l);
            chk("len", f_len, (own == 1) ? len_r : len_l);
            chk("en_l", en_l, f_en && own == 0);
            chk("en_r", en_r, f_en && own == 1);
            chk("done_l", done_l, f_done && own == 0);
            chk("done_r", done_r, f_done && own == 1);
            chk("addr_l", addr_l, f_addr);
            chk("addr_r", addr_r, f_addr);
`ifdef RD_DATA_REG_EN
            chk("rd_data", f_data, m_reg);
`else
            chk("rd_data", f_data, (dsel == 1) ? data_r : data_l);
`endif
        end
    end

    // 4-leaf tree: leaves A,B under t0, C,D under t1, root over t0/t1.
    logic          rst_t_n = 1'b0;
    logic          t_rdy [4];
    logic [PW-1:0] t_len [4];
    logic [3:0]    t_done;
    logic [3:0]    t_en;
    logic [AW-1:0] t_addr [4];
    logic [AW-1:0] n_addr [2];
    logic [DW-1:0] n_data [2];
    logic          n_en [2], n_done [2], n_rdy [2];
    logic [PW-1:0] n_len [2];
    logic [DW-1:0] rt_data;
    logic          rt_rdy;
    logic [PW-1:0] rt_len;
    logic          rt_done = 1'b0;

    for (genvar g = 0; g < 2; g++) begin : g_node
        fwd_combine #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) u_node (
            .clk                       (clk),
            .rst_n                     (rst_t_n),
            .forwarder_rd_addr_left    (t_addr[2*g]),
            .forwarder_rd_data_left    (64'h0),
            .forwarder_rd_en_left      (t_en[2*g]),
            .forwarder_done_left       (t_done[2*g]),
            .ready_for_forwarder_left  (t_rdy[2*g]),
            .len_to_forwarder_left     (t_len[2*g]),
            .forwarder_rd_addr_right   (t_addr[2*g+1]),
            .forwarder_rd_data_right   (64'h0),
            .forwarder_rd_en_right     (t_en[2*g+1]),
            .forwarder_done_right      (t_done[2*g+1]),
            .ready_for_forwarder_right (t_rdy[2*g+1]),
            .len_to_forwarder_right    (t_len[2*g+1]),
            .forwarder_rd_addr         (n_addr[g]),
            .forwarder_rd_data         (n_data[g]),
            .forwarder_rd_en           (n_en[g]),
            .forwarder_done            (n_done[g]),
            .ready_for_forwarder       (n_rdy[g]),
            .len_to_forwarder          (n_len[g])
        );
    end

    fwd_combine #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) u_root (
        .clk                       (clk),
        .rst_n                     (rst_t_n),
        .forwarder_rd_addr_left    (n_addr[0]),
        .forwarder_rd_data_left    (n_data[0]),
        .forwarder_rd_en_left      (n_en[0]),
        .forwarder_done_left       (n_done[0]),
        .ready_for_forwarder_left  (n_rdy[0]),
        .len_to_forwarder_left     (n_len[0]),
        .forwarder_rd_addr_right   (n_addr[1]),
        .forwarder_rd_data_right   (n_data[1]),
        .forwarder_rd_en_right     (n_en[1]),
        .forwarder_done_right      (n_done[1]),
        .ready_for_forwarder_right (n_rdy[1]),
        .len_to_forwarder_right    (n_len[1]),
        .forwarder_rd_addr         (10'd0),
        .forwarder_rd_data         (rt_data),
        .forwarder_rd_en           (1'b0),
        .forwarder_done            (rt_done),
        .ready_for_forwarder       (rt_rdy),
        .len_to_forwarder          (rt_len)
    );

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    typedef struct packed {
        logic          rl;
        logic          rr;
        logic          dn;
        logic          en;
        logic [AW-1:0] ad;
    } vec_t;

    vec_t vecs [12] = '{
        '{1'b1, 1'b1, 1'b0, 1'b1, 10'd2},
        '{1'b1, 1'b1, 1'b1, 1'b0, 10'd3},
        '{1'b1, 1'b1, 1'b0, 1'b1, 10'd4},
        '{1'b1, 1'b1, 1'b0, 1'b1, 10'd6},
        '{1'b1, 1'b1, 1'b1, 1'b0, 10'd7},
        '{1'b0, 1'b1, 1'b0, 1'b1, 10'd8},
        '{1'b0, 1'b0, 1'b0, 1'b0, 10'd9},
        '{1'b1, 1'b0, 1'b0, 1'b1, 10'd10},
        '{1'b1, 1'b0, 1'b1, 1'b1, 10'd11},
        '{1'b1, 1'b0, 1'b0, 1'b0, 10'd12},
        '{1'b0, 1'b1, 1'b1, 1'b1, 10'd13},
        '{1'b1, 1'b1, 1'b0, 1'b1, 10'd1}
    };

    initial begin
        int order [5] = '{1, 3, 2, 4, 1};

        for (int i = 0; i < 16; i++) begin
            mem_l[i] = 64'h1000 + 64'(i);
            mem_r[i] = 64'h2000 + 64'(i);
        end
        mem_l[5] = 64'h1234;
        mem_r[5] = 64'h5555;
        for (int i = 0; i < 4; i++) begin
            t_rdy[i] = 1'b0;
            t_len[i] = PW'(i + 1);
        end

        rst_n  = 1'b0;
        rdy_l  = 1'b1;
        rdy_r  = 1'b1;
        len_l  = 11'hA;
        len_r  = 11'hB;
        f_en   = 1'b0;
        f_done = 1'b0;
        f_addr = '0;
        step(1);
        chk_en = 1'b1;

        // Held in reset: left side presented, right gets nothing.
        f_done = 1'b1;
        f_en   = 1'b1;
        #1;
        chk("rst_len", f_len, 11'hA);
        chk("rst_en_r", en_r, 1'b0);
        chk("rst_done_r", done_r, 1'b0);
        step(1);
        f_done = 1'b0;
        f_en   = 1'b0;
        step(1);
`ifdef RD_DATA_REG_EN
        chk("rst_rd_data_zero", f_data, 64'h0);
`endif

        // Both ready after reset: left first, read addr 5 returns 0x1234.
        rst_n  = 1'b1;
        f_en   = 1'b1;
        f_addr = 10'd5;
        #1;
        chk("first_len", f_len, 11'hA);
        chk("first_en_l", en_l, 1'b1);
        chk("first_en_r", en_r, 1'b0);
        step(1);
        f_en = 1'b0;
`ifdef RD_DATA_REG_EN
        #1;
        chk("rd_data_not_early", f_data, 64'h0);
        step(1);
`endif
        chk("rd_lat_left", f_data, 64'h1234);

        // Done hands over to right although left still ready in that cycle.
        f_done = 1'b1;
        #1;
        chk("done_to_left", done_l, 1'b1);
        chk("done_not_right", done_r, 1'b0);
        step(1);
        f_done = 1'b0;
        rdy_l  = 1'b0;
        #1;
        chk("handover_len", f_len, 11'hB);
        chk("handover_rdy", f_rdy, 1'b1);

        f_en   = 1'b1;
        f_addr = 10'd5;
        #1;
        chk("right_en_r", en_r, 1'b1);
        chk("right_en_l", en_l, 1'b0);
        step(1);
        f_en = 1'b0;
`ifdef RD_DATA_REG_EN
        step(1);
`endif
        chk("rd_lat_right", f_data, 64'h5555);

        // Both idle, then a side rises and is taken within one cycle.
        rdy_r = 1'b0;
        step(3);
        chk("idle_rdy", f_rdy, 1'b0);
        rdy_l = 1'b1;
        #1;
        chk("rise_before", f_rdy, 1'b0);
        step(1);
        chk("rise_rdy", f_rdy, 1'b1);
        chk("rise_len", f_len, 11'hA);

        // Done to a not-ready owner is still forwarded.
        rdy_l  = 1'b0;
        f_done = 1'b1;
        #1;
        chk("done_unready", done_l, 1'b1);
        step(1);
        f_done = 1'b0;

        for (int i = 0; i < 12; i++) begin
            rdy_l  = vecs[i].rl;
            rdy_r  = vecs[i].rr;
            f_done = vecs[i].dn;
            f_en   = vecs[i].en;
            f_addr = vecs[i].ad;
            step(1);
        end

        // Reset mid-packet while right owns the port.
        rdy_l  = 1'b0;
        rdy_r  = 1'b1;
        f_done = 1'b0;
        f_en   = 1'b0;
        step(2);
        chk("pre_rst_len", f_len, 11'hB);
        rst_n  = 1'b0;
        f_en   = 1'b1;
        f_done = 1'b1;
        #1;
        chk("midrst_len", f_len, 11'hA);
        chk("midrst_en_r", en_r, 1'b0);
        chk("midrst_done_r", done_r, 1'b0);
        chk("midrst_en_l", en_l, 1'b1);
        step(2);
        rst_n  = 1'b1;
        f_en   = 1'b0;
        f_done = 1'b0;
        #1;
        chk("post_rst_rdy", f_rdy, 1'b0);
        step(1);
        chk("post_rst_len", f_len, 11'hB);
        step(2);
        chk_en = 1'b0;

        // Tree: all leaves ready -> A, C, B, D, A.
        for (int i = 0; i < 4; i++) t_rdy[i] = 1'b1;
        step(2);
        rst_t_n = 1'b1;
        #1;
        for (int k = 0; k < 5; k++) begin
            chk("tree_order", rt_len, 64'(order[k]));
            if (k < 4) begin
                rt_done = 1'b1;
                #1;
                chk("tree_done_leaf", t_done, 64'(4'b0001 << (order[k] - 1)));
                step(1);
                rt_done = 1'b0;
                #1;
            end
        end
        for (int i = 0; i < 4; i++) t_rdy[i] = 1'b0;
        step(3);
        chk("tree_idle", rt_rdy, 1'b0);
        t_rdy[2] = 1'b1;
        #1;
        chk("tree_c_before", rt_rdy, 1'b0);
        step(1);
        chk("tree_c_rdy", rt_rdy, 1'b1);
        chk("tree_c_len", rt_len, 11'd3);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
